// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD conversion / scanned 7-segment display block.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // Active-high segments, bit6=a .. bit0=g.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef logic [1:0] conv_state_t;

    localparam conv_state_t ST_IDLE  = 2'd0;
    localparam conv_state_t ST_SHIFT = 2'd1;
    localparam conv_state_t ST_DONE  = 2'd2;

    function automatic int unsigned bit_cnt_width(input int unsigned bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-high 7-segment pattern; non-decimal codes are blanked.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Serial shift-add-3 binary-to-BCD converter feeding a time-multiplexed 7-segment bank
// with leading-zero blanking and over-range dash display.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int unsigned BIN_W       = 10,
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned MAX_VAL     = 999,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_en
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = bit_cnt_width(BIN_W);
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // When MAX_VAL does not fit in BIN_W bits, no input can exceed it.
    localparam bit               MAX_FITS = (BIN_W >= 32) || ((64'(MAX_VAL) >> BIN_W) == 64'd0);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   work_q, work_d, work_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               bin_over;

    logic [PRE_W-1:0]   pre_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         cur_digit;
    logic               lead_zero;
    logic [6:0]         dec_seg;

    assign bin_over = MAX_FITS ? (bin > MAX_BIN) : 1'b0;

    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d    = bin;
                    work_d     = '0;
                    ovf_pend_d = bin_over;
                    cnt_d      = CNT_W'(BIN_W - 1);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Bits carried out of the top nibble are dropped; ovf covers that case.
                {work_d, shreg_d} = {work_adj, shreg_q} << 1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                bcd_d   = work_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Refresh scan runs freely, decoupled from the converter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        lead_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i == int'(idx_q)) begin
                cur_digit = bcd_q[4*i +: 4];
            end
            if (i >= int'(idx_q) && bcd_q[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
    end

    seg7_decode u_dec (
        .code (cur_digit),
        .seg  (dec_seg)
    );

    always_comb begin
        if (ovf_q) begin
            seg = SEG_DASH;
        end else if (LZ_BLANK != 0 && idx_q != '0 && lead_zero) begin
            seg = SEG_BLANK;
        end else begin
            seg = dec_seg;
        end
    end

    assign dig_en = DIGITS'(1) << idx_q;
    assign busy   = (state_q == ST_SHIFT);
    assign done   = done_q;
    assign bcd    = bcd_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench: three configurations (blanking on, blanking off, 14-bit/4-digit).
module tb_bcd_scan_display;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
    logic [9:0]  bin_a = '0, bin_b = '0;
    logic [13:0] bin_c = '0;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
    logic [11:0] bcd_a, bcd_b;
    logic [15:0] bcd_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic [2:0]  dig_a, dig_b;
    logic [3:0]  dig_c;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.BIN_W(10), .DIGITS(3), .MAX_VAL(999), .REFRESH_DIV(4), .LZ_BLANK(1)) u_a (
        .clk(clk), .rst(rst), .load(load_a), .bin(bin_a), .busy(busy_a), .done(done_a),
        .bcd(bcd_a), .ovf(ovf_a), .seg(seg_a), .dig_en(dig_a)
    );

    bcd_scan_display #(.BIN_W(10), .DIGITS(3), .MAX_VAL(999), .REFRESH_DIV(4), .LZ_BLANK(0)) u_b (
        .clk(clk), .rst(rst), .load(load_b), .bin(bin_b), .busy(busy_b), .done(done_b),
        .bcd(bcd_b), .ovf(ovf_b), .seg(seg_b), .dig_en(dig_b)
    );

    bcd_scan_display #(.BIN_W(14), .DIGITS(4), .MAX_VAL(9999), .REFRESH_DIV(4), .LZ_BLANK(1)) u_c (
        .clk(clk), .rst(rst), .load(load_c), .bin(bin_c), .busy(busy_c), .done(done_c),
        .bcd(bcd_c), .ovf(ovf_c), .seg(seg_c), .dig_en(dig_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load v into instance `which`; lat = edges from the load edge until done is seen (0 = timeout).
    task automatic run(input int which, input logic [13:0] v, output int lat);
        logic seen;
        @(negedge clk);
        case (which)
            0:       begin bin_a = v[9:0]; load_a = 1'b1; end
            1:       begin bin_b = v[9:0]; load_b = 1'b1; end
            default: begin bin_c = v;      load_c = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        load_a = 1'b0;
        load_b = 1'b0;
        load_c = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if ((which == 0 && done_a) || (which == 1 && done_b) || (which == 2 && done_c)) begin
                    lat  = k;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic check_scan(input int which, input string tag,
                              input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        logic [6:0] exp_seg [3];
        logic [2:0] want;
        logic [2:0] de;
        int n;
        exp_seg = '{e0, e1, e2};
        for (int d = 0; d < 3; d++) begin
            want = 3'b001 << d;
            de   = (which == 0) ? dig_a : dig_b;
            n    = 0;
            while (de != want && n < 20) begin
                @(posedge clk);
                #1;
                n++;
                de = (which == 0) ? dig_a : dig_b;
            end
            check_eq($sformatf("%s_en%0d", tag, d), {31'd0, de == want}, 32'd1);
            check_eq($sformatf("%s_seg%0d", tag, d), (which == 0) ? seg_a : seg_b, exp_seg[d]);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    initial begin
        int lat;
        int dn_cnt;
        int dn_first;
        int dn_second;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_bcd", bcd_a, 0);
        check_eq("rst_ovf", ovf_a, 0);
        check_eq("rst_dig", dig_a, 3'b001);
        check_eq("rst_seg", seg_a, 7'b1111110);
        @(negedge clk);
        rst = 1'b0;
        // Digit 0 stays enabled for REFRESH_DIV=4 cycles after reset release
        repeat (3) @(posedge clk);
        #1;
        check_eq("scan_hold", dig_a, 3'b001);
        @(posedge clk);
        #1;
        check_eq("scan_step", dig_a, 3'b010);

        // Small value, blanking on and off
        run(0, 14'd7, lat);
        check_eq("a7_lat", lat, 11);
        check_eq("a7_bcd", bcd_a, 12'h007);
        check_scan(0, "a7", 7'b1110000, 7'b0000000, 7'b0000000);
        run(1, 14'd7, lat);
        check_eq("b7_bcd", bcd_b, 12'h007);
        check_scan(1, "b7", 7'b1110000, 7'b1111110, 7'b1111110);

        // done in the 12th cycle after the load edge, i.e. seen after edge N+11
        run(0, 14'd523, lat);
        check_eq("a523_lat", lat, 11);
        check_eq("a523_bcd", bcd_a, 12'h523);
        check_eq("a523_ovf", ovf_a, 0);
        check_scan(0, "a523", 7'b1111001, 7'b1101101, 7'b1011011);

        // Reset in the middle of a conversion
        @(negedge clk);
        bin_a  = 10'd523;
        load_a = 1'b1;
        @(posedge clk);
        #1;
        load_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_busy_pre", busy_a, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_busy", busy_a, 0);
        check_eq("mid_bcd", bcd_a, 0);
        check_eq("mid_ovf", ovf_a, 0);
        check_eq("mid_dig", dig_a, 3'b001);
        check_eq("mid_seg", seg_a, 7'b1111110);
        @(negedge clk);
        rst = 1'b0;
        dn_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) dn_cnt++;
        end
        check_eq("mid_no_done", dn_cnt, 0);

        // Over-range then zero
        run(0, 14'd1023, lat);
        check_eq("a1023_ovf", ovf_a, 1);
        check_scan(0, "a1023", 7'b0000001, 7'b0000001, 7'b0000001);
        run(0, 14'd0, lat);
        check_eq("a0_ovf", ovf_a, 0);
        check_eq("a0_bcd", bcd_a, 0);
        check_scan(0, "a0", 7'b1111110, 7'b0000000, 7'b0000000);

        // Loads during SHIFT and DONE are ignored; load after done is accepted
        @(negedge clk);
        bin_a  = 10'd999;
        load_a = 1'b1;
        @(posedge clk);
        #1;
        load_a    = 1'b0;
        dn_cnt    = 0;
        dn_first  = 0;
        dn_second = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                dn_cnt++;
                if (dn_cnt == 1) dn_first = k;
                if (dn_cnt == 2) dn_second = k;
            end
            if (k == 11) check_eq("ign_bcd999", bcd_a, 12'h999);
            if (k == 20) check_eq("ign_hold", bcd_a, 12'h999);
            load_a = (k == 2 || k == 10 || k == 12);
            if (k == 2) bin_a = 10'd5;
            if (k == 12) bin_a = 10'd321;
        end
        load_a = 1'b0;
        check_eq("ign_dn_cnt", dn_cnt, 2);
        check_eq("ign_dn_first", dn_first, 11);
        check_eq("ign_dn_second", dn_second, 24);
        check_eq("ign_bcd321", bcd_a, 12'h321);

        // Wide configuration sweep against a decimal reference
        for (int v = 0; v <= 9999; v += 37) begin
            run(2, 14'(v), lat);
            check_eq($sformatf("c%0d_bcd", v), bcd_c, ref_bcd(v));
            check_eq($sformatf("c%0d_ovf", v), ovf_c, 0);
        end
        run(2, 14'd9999, lat);
        check_eq("c9999_lat", lat, 15);
        check_eq("c9999_bcd", bcd_c, 16'h9999);
        run(2, 14'd16383, lat);
        check_eq("c16383_ovf", ovf_c, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
